// File: rtl/dma_pkg.sv
// dma_pkg: shared types, channel count and helpers for the DMA channel arbiter
package dma_pkg;
  localparam int NUM_CH = 4;
  typedef enum logic [1:0] {IDLE, HOLD_WAIT, SERVICE} arb_state_t;
  function automatic logic [1:0] onehot_to_ch(input logic [NUM_CH-1:0] oh);
    onehot_to_ch = 2'd0;
    for (int i = 0; i < NUM_CH; i++) if (oh[i]) onehot_to_ch = 2'(i);
  endfunction
endpackage

// File: rtl/dma_prio_resolver.sv
// dma_prio_resolver: picks the highest-priority pending channel, fixed or rotating
module dma_prio_resolver import dma_pkg::*; (
  input  logic [NUM_CH-1:0] pend,
  input  logic [1:0]        last,
  input  logic              rotate,
  output logic [1:0]        winner,
  output logic              valid
);
  logic [1:0] base;
  assign base = rotate ? last : 2'd3;
  // scan from lowest to highest priority so the last hit is the winner
  always_comb begin
    winner = 2'd0;
    valid  = 1'b0;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (pend[base + 2'(i)]) begin
        winner = base + 2'(i);
        valid  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dma_channel_arbiter.sv
// dma_channel_arbiter: request combining, HRQ/HLDA handshake and channel grant for the DMA controller
module dma_channel_arbiter import dma_pkg::*; (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              DREQ_Sense,
  input  logic              DACK_Sense,
  input  logic [NUM_CH-1:0] RequestReg,
  input  logic [NUM_CH-1:0] MaskedReg,
  input  logic              RotatingPriority,
  input  logic              MemToMem,
  input  logic              PriorityGen,
  input  logic              ldAck,
  input  logic              HLDA,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic [NUM_CH-1:0] DMA_Req,
  output logic [1:0]        ActiveChannel,
  output logic              Busy
);
  arb_state_t        state, state_nxt;
  logic [NUM_CH-1:0] dreq_eff, raw, pend, grant, grant_nxt;
  logic [1:0]        last, last_nxt, winner;
  logic              valid;
  assign dreq_eff = DREQ ^ {NUM_CH{DREQ_Sense}};
  assign raw      = (dreq_eff & ~MaskedReg) | RequestReg;
  assign pend     = MemToMem ? {{(NUM_CH-1){1'b0}}, raw[0]} : raw;
  dma_prio_resolver u_prio (
    .pend   (pend),
    .last   (last),
    .rotate (RotatingPriority),
    .winner (winner),
    .valid  (valid)
  );
  // state, grant and rotation pointer; reset clears everything without a clock
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      grant <= '0;
      last  <= 2'd3;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end
  // handshake sequencing; the grant is frozen in SERVICE until ldAck or loss of HLDA
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = RotatingPriority ? last : 2'd3;
    if (state == IDLE) begin
      state_nxt = |pend ? HOLD_WAIT : IDLE;
    end else if (state == HOLD_WAIT) begin
      if (!(|pend)) state_nxt = IDLE;
      else if (HLDA && PriorityGen && valid) begin
        state_nxt = SERVICE;
        grant_nxt = NUM_CH'(1) << winner;
      end
    end else if (ldAck || !HLDA) begin
      state_nxt = IDLE;
      grant_nxt = '0;
      if (ldAck && RotatingPriority) last_nxt = onehot_to_ch(grant);
    end
  end
  assign HRQ           = state != IDLE;
  assign Busy          = state != IDLE;
  assign DMA_Req       = grant;
  assign ActiveChannel = onehot_to_ch(grant);
  assign DACK          = (MemToMem ? '0 : grant) ^ {NUM_CH{~DACK_Sense}};
endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb_dma_channel_arbiter: directed scoreboard bench for the DMA channel arbiter
module tb_dma_channel_arbiter;
  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] DREQ, RequestReg, MaskedReg;
  logic       DREQ_Sense, DACK_Sense, RotatingPriority, MemToMem, PriorityGen, ldAck, HLDA;
  logic       HRQ, Busy;
  logic [3:0] DACK, DMA_Req;
  logic [1:0] ActiveChannel;

  typedef struct {
    string      tag;
    logic [11:0] v;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  dma_channel_arbiter dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .DREQ_Sense(DREQ_Sense), .DACK_Sense(DACK_Sense),
    .RequestReg(RequestReg), .MaskedReg(MaskedReg), .RotatingPriority(RotatingPriority),
    .MemToMem(MemToMem), .PriorityGen(PriorityGen), .ldAck(ldAck), .HLDA(HLDA),
    .HRQ(HRQ), .DACK(DACK), .DMA_Req(DMA_Req), .ActiveChannel(ActiveChannel), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [11:0] pk(input logic h, input logic b, input logic [3:0] r,
                                     input logic [1:0] a, input logic [3:0] d);
    return {h, b, r, a, d};
  endfunction

  task automatic push(input string tag, input logic [11:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [11:0] obs;
    obs = {HRQ, Busy, DMA_Req, ActiveChannel, DACK};
    n_checks++;
    if (q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h expected an entry", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s: observed hrq/busy/req/ach/dack=%h expected %h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic step(input string tag, input logic [11:0] v);
    push(tag, v);
    tick();
    pop_check();
  endtask

  initial begin
    logic [3:0] oh;
    RESET_N = 1'b0; DREQ = '0; RequestReg = '0; MaskedReg = '0;
    DREQ_Sense = 0; DACK_Sense = 0; RotatingPriority = 0; MemToMem = 0;
    PriorityGen = 0; ldAck = 0; HLDA = 0;
    tick();
    step("reset", pk(0, 0, 4'b0, 2'd0, 4'hF));
    RESET_N = 1'b1;
    tick();
    // fixed priority
    DREQ = 4'b1010;
    step("fixed_hrq", pk(1, 1, 4'b0, 2'd0, 4'hF));
    HLDA = 1; PriorityGen = 1;
    step("fixed_grant", pk(1, 1, 4'b0010, 2'd1, 4'b1101));
    PriorityGen = 0; DREQ = 4'b0;
    step("fixed_hold", pk(1, 1, 4'b0010, 2'd1, 4'b1101));
    ldAck = 1;
    step("fixed_done", pk(0, 0, 4'b0, 2'd0, 4'hF));
    ldAck = 0; HLDA = 0;
    // rotating priority, five services
    RotatingPriority = 1; DREQ = 4'hF;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      step("rot_hrq", pk(1, 1, 4'b0, 2'd0, 4'hF));
      HLDA = 1; PriorityGen = 1;
      step("rot_grant", pk(1, 1, oh, 2'(k % 4), ~oh));
      PriorityGen = 0; ldAck = 1;
      step("rot_done", pk(0, 0, 4'b0, 2'd0, 4'hF));
      ldAck = 0; HLDA = 0;
    end
    RotatingPriority = 0; DREQ = 4'b0;
    step("back_fixed", pk(0, 0, 4'b0, 2'd0, 4'hF));
    // masks block DREQ, software request still wins
    MaskedReg = 4'hF; DREQ = 4'hF;
    tick();
    step("masked_idle", pk(0, 0, 4'b0, 2'd0, 4'hF));
    RotatingPriority = 1; RequestReg = 4'b0100;
    step("swreq_hrq", pk(1, 1, 4'b0, 2'd0, 4'hF));
    HLDA = 1; PriorityGen = 1;
    step("swreq_grant", pk(1, 1, 4'b0100, 2'd2, 4'b1011));
    PriorityGen = 0; HLDA = 0;
    step("abort", pk(0, 0, 4'b0, 2'd0, 4'hF));
    // abort must not move the pointer: next rotating win from last=3 is ch0
    RequestReg = 4'b0; MaskedReg = 4'b0; DREQ = 4'hF;
    step("abort_hrq", pk(1, 1, 4'b0, 2'd0, 4'hF));
    HLDA = 1; PriorityGen = 1;
    step("abort_last", pk(1, 1, 4'b0001, 2'd0, 4'b1110));
    PriorityGen = 0; ldAck = 1;
    step("abort_done", pk(0, 0, 4'b0, 2'd0, 4'hF));
    ldAck = 0; HLDA = 0; DREQ = 4'b0; RotatingPriority = 0;
    tick();
    // withdrawal before hold
    DREQ = 4'b0001;
    step("wd_hrq", pk(1, 1, 4'b0, 2'd0, 4'hF));
    DREQ = 4'b0;
    step("wd_drop", pk(0, 0, 4'b0, 2'd0, 4'hF));
    step("wd_idle", pk(0, 0, 4'b0, 2'd0, 4'hF));
    // active-low DREQ, active-high DACK
    DREQ_Sense = 1; DACK_Sense = 1; DREQ = 4'b1110;
    step("pol_hrq", pk(1, 1, 4'b0, 2'd0, 4'h0));
    HLDA = 1; PriorityGen = 1;
    step("pol_grant", pk(1, 1, 4'b0001, 2'd0, 4'b0001));
    PriorityGen = 0; DREQ_Sense = 0;
    step("pol_hold", pk(1, 1, 4'b0001, 2'd0, 4'b0001));
    ldAck = 1;
    step("pol_done", pk(0, 0, 4'b0, 2'd0, 4'h0));
    ldAck = 0; HLDA = 0; DREQ = 4'b0; DACK_Sense = 0;
    tick();
    // memory-to-memory: only ch0 eligible, DACK inactive
    MemToMem = 1; DREQ = 4'b0010;
    tick();
    step("m2m_nohrq", pk(0, 0, 4'b0, 2'd0, 4'hF));
    DREQ = 4'b0001;
    step("m2m_hrq", pk(1, 1, 4'b0, 2'd0, 4'hF));
    HLDA = 1; PriorityGen = 1;
    step("m2m_grant", pk(1, 1, 4'b0001, 2'd0, 4'hF));
    PriorityGen = 0; MemToMem = 0;
    step("svc_dack", pk(1, 1, 4'b0001, 2'd0, 4'b1110));
    // asynchronous reset mid-service
    push("async_reset", pk(0, 0, 4'b0, 2'd0, 4'hF));
    #1 RESET_N = 1'b0;
    #1 pop_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
